// File: rtl/perf_seg_display_pkg.sv
// Shared definitions for the performance-counter 7-segment display.
//   SEL_* : display select codes driven by the mode switches
//   SEG_BLANK : all segments off (active-low)
//   hex_to_seg : nibble -> active-low gfedcba pattern
package perf_disp_pkg;

  typedef enum logic [2:0] {
    SEL_MEM = 3'd0,
    SEL_PC  = 3'd1,
    SEL_CYC = 3'd2,
    SEL_CBR = 3'd3,
    SEL_TKN = 3'd4,
    SEL_JMP = 3'd5
  } sel_e;

  localparam int unsigned DISP_W     = 32;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned IDX_W      = 3;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low segment pattern for one hex digit, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/perf_seg_display_if.sv
// Pipeline tap bundle feeding the performance display.
//   pc, mem_data           : 32-bit values available for display
//   ret_valid/_cond_br/_taken/_jump : per-cycle retire event flags
// master = core side (drives), slave = display side (samples).
interface perf_seg_display_if;
  import perf_disp_pkg::*;

  logic [DISP_W-1:0] pc;
  logic [DISP_W-1:0] mem_data;
  logic              ret_valid;
  logic              ret_cond_br;
  logic              ret_taken;
  logic              ret_jump;

  modport master (
    output pc, mem_data, ret_valid, ret_cond_br, ret_taken, ret_jump
  );

  modport slave (
    input  pc, mem_data, ret_valid, ret_cond_br, ret_taken, ret_jump
  );

endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder.
//   nib_i   : 4-bit hex digit
//   seg_c_o : gfedcba, active-low (combinational)
module seg7_hex_decoder
  import perf_disp_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = hex_to_seg(nib_i);

endmodule

// File: rtl/perf_seg_display.sv
// Pipeline performance counters shown as 8 hex digits on a multiplexed
// 7-segment display.
//   clk, reset     : clock, async active-low reset
//   clr            : sync clear of counters and snapshot
//   halt           : freezes counters, lights the leftmost dp
//   pro_reset      : display select
//   core           : pipeline taps (pc, mem_data, retire flags)
//   seg, an        : active-low segments {dp,gfedcba} and digit enables
module perf_seg_display
  import perf_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  halt,
  input  logic [2:0]            pro_reset,
  perf_seg_display_if.slave     core,
  output logic [7:0]            seg,
  output logic [7:0]            an
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]  cbr_cnt_q, cbr_cnt_d;
  logic [CNT_W-1:0]  tkn_cnt_q, tkn_cnt_d;
  logic [CNT_W-1:0]  jmp_cnt_q, jmp_cnt_d;
  logic [DISP_W-1:0] snap_q, snap_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic [DISP_W-1:0] sel_val_c;
  logic              scan_wrap_c;
  logic              is_cbr_c;
  logic [6:0]        dec_seg_c;

  // Select mux; unused codes show zero.
  always_comb begin
    sel_val_c = '0;
    case (pro_reset)
      SEL_MEM: sel_val_c = core.mem_data;
      SEL_PC:  sel_val_c = core.pc;
      SEL_CYC: sel_val_c = DISP_W'(cyc_cnt_q);
      SEL_CBR: sel_val_c = DISP_W'(cbr_cnt_q);
      SEL_TKN: sel_val_c = DISP_W'(tkn_cnt_q);
      SEL_JMP: sel_val_c = DISP_W'(jmp_cnt_q);
      default: sel_val_c = '0;
    endcase
  end

  assign scan_wrap_c = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
  assign is_cbr_c    = core.ret_valid && core.ret_cond_br;

  seg7_hex_decoder u_dec (
    .nib_i   (snap_q[{idx_q, 2'b00} +: NIB_W]),
    .seg_c_o (dec_seg_c)
  );

  // Next-state: counters (clr > halt > count), scan, snapshot, outputs.
  always_comb begin
    cyc_cnt_d  = cyc_cnt_q;
    cbr_cnt_d  = cbr_cnt_q;
    tkn_cnt_d  = tkn_cnt_q;
    jmp_cnt_d  = jmp_cnt_q;
    snap_d     = snap_q;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;

    if (clr) begin
      cyc_cnt_d = '0;
      cbr_cnt_d = '0;
      tkn_cnt_d = '0;
      jmp_cnt_d = '0;
    end else if (!halt) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if (is_cbr_c)
        cbr_cnt_d = cbr_cnt_q + CNT_W'(1);
      if (is_cbr_c && core.ret_taken)
        tkn_cnt_d = tkn_cnt_q + CNT_W'(1);
      if (core.ret_valid && core.ret_jump)
        jmp_cnt_d = jmp_cnt_q + CNT_W'(1);
    end

    if (scan_wrap_c) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + IDX_W'(1);
    end

    // Whole-frame snapshot at the 7->0 digit wrap avoids tearing.
    if (clr)
      snap_d = '0;
    else if (scan_wrap_c && (idx_q == IDX_W'(NUM_DIGITS - 1)))
      snap_d = sel_val_c;

    an_d  = ~(8'b1 << idx_q);
    seg_d = {!((idx_q == IDX_W'(NUM_DIGITS - 1)) && halt), dec_seg_c};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_q  <= '0;
      cbr_cnt_q  <= '0;
      tkn_cnt_q  <= '0;
      jmp_cnt_q  <= '0;
      snap_q     <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      an_q       <= SEG_BLANK;
      seg_q      <= SEG_BLANK;
    end else begin
      cyc_cnt_q  <= cyc_cnt_d;
      cbr_cnt_q  <= cbr_cnt_d;
      tkn_cnt_q  <= tkn_cnt_d;
      jmp_cnt_q  <= jmp_cnt_d;
      snap_q     <= snap_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_perf_seg_display.sv
// Directed bench for perf_seg_display with SCAN_DIV=4 (32-cycle frames).
module tb_perf_seg_display;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       halt;
  logic [2:0] pro_reset;
  logic [7:0] seg;
  logic [7:0] an;

  int vectors     = 0;
  int miscompares = 0;

  perf_seg_display_if core_if ();

  perf_seg_display #(.SCAN_DIV(4), .CNT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .halt      (halt),
    .pro_reset (pro_reset),
    .core      (core_if),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference segment table (gfedcba, active-low).
  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting on the first cycle of digit 'first', check every remaining
  // digit of the frame: an held 4 cycles, seg pattern and dp.
  task automatic check_digits(input string tag, input logic [31:0] val, input int first);
    logic [7:0] exp_an;
    logic [3:0] nib;
    logic       dp_exp;
    for (int d = first; d < 8; d++) begin
      exp_an = ~(8'b1 << d);
      nib    = val[d*4 +: 4];
      dp_exp = !((d == 7) && halt);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s an d%0d c%0d", tag, d, c), 32'(an), 32'(exp_an));
        if (c == 0)
          chk($sformatf("%s seg d%0d", tag, d), 32'(seg), 32'({dp_exp, seg_ref(nib)}));
        @(negedge clk);
      end
    end
  endtask

  // Advance to the first cycle of a freshly started digit d.
  task automatic wait_digit_start(input int d);
    logic [7:0] target;
    int n;
    target = ~(8'b1 << d);
    n = 0;
    while (an === target && n < 100) begin @(negedge clk); n++; end
    while (an !== target && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("sync d%0d in budget", d), 32'(n < 100), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] val);
    wait_digit_start(0);
    check_digits(tag, val, 0);
  endtask

  // Retire event vectors {valid, cond_br, taken, jump}.
  logic [3:0] ev [9] = '{4'b1110, 4'b1110, 4'b1110, 4'b1100, 4'b1100,
                         4'b1101, 4'b1010, 4'b1001, 4'b0110};

  initial begin
    reset             = 1'b0;
    clr               = 1'b0;
    halt              = 1'b1;
    pro_reset         = 3'b010;
    core_if.pc        = '0;
    core_if.mem_data  = '0;
    core_if.ret_valid   = 1'b0;
    core_if.ret_cond_br = 1'b0;
    core_if.ret_taken   = 1'b0;
    core_if.ret_jump    = 1'b0;

    // 1. Reset, mid-scan async reset, then a full frame of zeros.
    @(negedge clk);
    chk("reset an", 32'(an), 32'hFF);
    chk("reset seg", 32'(seg), 32'hFF);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async reset an", 32'(an), 32'hFF);
    chk("async reset seg", 32'(seg), 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_digits("post reset", 32'h0, 0);

    // 2. 100 unhalted cycles of cyc_cnt.
    halt = 1'b0;
    repeat (100) @(negedge clk);
    halt = 1'b1;
    check_frame("cyc 100", 32'h0000_0064);

    // 3. Retire events.
    pro_reset = 3'b011;
    halt = 1'b0;
    for (int i = 0; i < 9; i++) begin
      {core_if.ret_valid, core_if.ret_cond_br, core_if.ret_taken, core_if.ret_jump} = ev[i];
      @(negedge clk);
    end
    {core_if.ret_valid, core_if.ret_cond_br, core_if.ret_taken, core_if.ret_jump} = 4'b0000;
    halt = 1'b1;
    check_frame("cbr", 32'd6);
    pro_reset = 3'b100;
    check_frame("tkn", 32'd3);
    pro_reset = 3'b101;
    check_frame("jmp", 32'd2);
    pro_reset = 3'b110;
    check_frame("sel110", 32'd0);
    pro_reset = 3'b111;
    check_frame("sel111", 32'd0);

    // 4. Back-door preload then wrap.
    pro_reset = 3'b010;
    force dut.cyc_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.cyc_cnt_q;
    halt = 1'b0;
    repeat (3) @(negedge clk);
    halt = 1'b1;
    check_frame("cyc wrap", 32'h0000_0001);

    // 5. clr with halt: counters and snap cleared, scan keeps going.
    wait_digit_start(4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr an c1", 32'(an), 32'hEF);
    @(negedge clk);
    chk("clr an c2", 32'(an), 32'hEF);
    @(negedge clk);
    chk("clr an c3", 32'(an), 32'hEF);
    @(negedge clk);
    chk("clr an next digit", 32'(an), 32'hDF);
    check_frame("clr cyc", 32'd0);
    pro_reset = 3'b011;
    check_frame("clr cbr", 32'd0);
    pro_reset = 3'b101;
    check_frame("clr jmp", 32'd0);

    // 6. Select change mid-frame: rest of frame keeps old snapshot.
    halt = 1'b0;
    core_if.pc       = 32'h1234_5678;
    core_if.mem_data = 32'hDEAD_BEEF;
    pro_reset = 3'b001;
    check_frame("pc", 32'h1234_5678);
    wait_digit_start(3);
    pro_reset = 3'b000;
    check_digits("pc tail", 32'h1234_5678, 3);
    check_digits("mem", 32'hDEAD_BEEF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
